mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sits between if_stage/mem_stage and the memory. Serialises their accesses over a req/ack bus.
- Drives stall_if and stall_mem so the pipeline holds while a requester waits.
- Fixed priority: MEM over IF, because the older instruction must retire first.

Parameters:
ADDR_W, 32, address width (matches `AddrBus)
DATA_W, 32, data width (matches `DataBus)
TIMEOUT, 16, cycles to wait for bus_ack before forced termination (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset_  input  1  asynchronous, active-low reset
if_req  input  1  IF read request, level; held until if_ack
if_addr  input  ADDR_W  IF fetch address; stable while if_req is high
if_rdata  output  DATA_W  fetched instruction; valid while if_ack is high
if_ack  output  1  one-cycle completion pulse to IF
mem_req  input  1  MEM request, level; held until mem_ack
mem_we  input  1  1 = write, 0 = read
mem_addr  input  ADDR_W  MEM address
mem_wdata  input  DATA_W  store data
mem_rdata  output  DATA_W  load data; valid while mem_ack is high
mem_ack  output  1  one-cycle completion pulse to MEM
bus_req  output  1  request to memory; held until bus_ack
bus_we  output  1  write strobe to memory
bus_addr  output  ADDR_W  memory address
bus_wdata  output  DATA_W  memory write data
bus_rdata  input  DATA_W  memory read data; valid with bus_ack
bus_ack  input  1  memory completion; may be asserted in the first bus_req cycle
stall_if  output  1  if_req & ~if_ack
stall_mem  output  1  mem_req & ~mem_ack
owner  output  2  current grant: 0 none, 1 IF, 2 MEM
bus_err  output  1  timeout pulse (optional feature)

Behaviour:
- Reset is asynchronous and active-low. While reset_ is low, every output is 0, including the rdata registers, owner, the acks and the bus outputs. stall_* then follow their equations.
- Reset mid-transaction abandons the access. bus_req drops immediately, and the memory must tolerate this.
- All outputs are registered except stall_if and stall_mem, which are combinational from req and the registered ack.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - mem_req → latch mem_addr, mem_we, mem_wdata into the bus registers; bus_req=1; owner=2; go to BUS.
  - else if_req → latch if_addr; bus_we=0; owner=1; go to BUS.
  - else stay in IDLE.
- BUS:
  - Hold all bus outputs stable.
  - On bus_ack, at the next edge: bus_req=0; the owner's ack=1; owner's rdata ← bus_rdata (reads only; on a write mem_rdata keeps its previous value); go to RESP.
- RESP (exactly one cycle):
  - The ack is high during this cycle.
  - The just-served requester's req is ignored this cycle, since it still shows the old request.
  - If the other requester is requesting, grant it directly (same latching as IDLE) and go to BUS.
  - Otherwise go to IDLE.
- Requester rule: a requester may change or drop req only at the edge ending its ack cycle.
- Latency:
  - Minimum 2 cycles from req sampled to ack visible, when bus_ack is returned in the first BUS cycle.
  - Each extra memory wait cycle adds 1.
  - Back-to-back service of the same requester: one access per 3 cycles.
- Simultaneous requests in IDLE: MEM wins. IF is granted from RESP of the MEM access.
- Deliberate priority inversion: if mem_req rises while IF is in BUS, IF completes first. There is no preemption.
- bus_ack while not in BUS is ignored.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on entry to BUS and increments each BUS cycle.
  - If it reaches TIMEOUT-1 without bus_ack, the arbiter terminates the access as if acked: owner's rdata = 32'hDEADBEEF, ack pulse issued, bus_err=1 for that one cycle, then RESP.
  - A bus_ack arriving in the same cycle as the timeout wins: normal data is returned and bus_err=0.
- Without the macro: no counter; BUS waits indefinitely; bus_err is tied to 0.

Decomposition:
- defines.v gets:
  - ArbIdle/ArbBus/ArbResp state codes;
  - owner codes OwnNone/OwnIf/OwnMem;
  - `ArbErrData (32'hDEADBEEF).
- Existing `ENABLED, `AddrBus and `DataBus are reused.
- One natural sub-module: arb_watchdog, holding the timeout counter and compare. It is instantiated only under MEM_ARBITER_TIMEOUT_EN.

Test Plan:
- Single IF read, memory acks same cycle, bus_rdata=0x2002000A → bus_req high 1 cycle, if_ack on cycle 2, if_rdata=0x2002000A, stall_if high for cycles 0–1.
- IF and MEM both request in one cycle, MEM write addr 0x40 data 0x55 → MEM granted first (owner=2, bus_we=1), mem_ack, then RESP grants IF directly (owner=1); mem_rdata unchanged.
- Memory inserts 3 wait cycles on MEM read at 0x80 → bus outputs stable 4 cycles, mem_ack 5 cycles after the request, stall_mem high the whole time.
- mem_req rises while IF is in BUS → IF completes, then MEM is served; no preemption, no lost request.
- reset_ pulled low in BUS → bus_req, owner and both acks go to 0 immediately; after release FSM is in IDLE and a fresh IF request completes normally.
- With MEM_ARBITER_TIMEOUT_EN, TIMEOUT=16 and bus_ack never asserted → ack after 16 BUS cycles with rdata=0xDEADBEEF and a single-cycle bus_err pulse.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the unified-memory arbiter:
//               FSM state codes, bus owner codes and the data word returned
//               on a forced (timed-out) access.
// Revision    : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbBus  = 2'd1,
        ArbResp = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnIf   = 2'd1,
        OwnMem  = 2'd2
    } arb_owner_e;

    // Returned to the requester when the memory never answers.
    localparam logic [31:0] ArbErrData = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_watchdog
// Description : Bus-cycle counter for the arbiter timeout. The count is held
//               at zero outside the BUS state, so it restarts on every entry
//               into BUS, and expired_o flags the BUS cycle in which the count
//               reaches TIMEOUT-1.
// Revision    : 1.0  initial release
// Ports       : clk_i     system clock, rising edge
//               rst_n     asynchronous active-low reset
//               in_bus_i  arbiter is in the BUS state this cycle
//               expired_o last permitted BUS cycle without bus_ack
// ============================================================================
module mem_arbiter_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic in_bus_i,
    output logic expired_o
);

    localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (in_bus_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = in_bus_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises IF (read-only) and MEM (load/store) accesses onto a
//               single req/ack memory bus. MEM has fixed priority in IDLE; an
//               access already on the bus is never preempted. The RESP state
//               hands the bus straight to the other requester if it waits.
//               Optional macro MEM_ARBITER_TIMEOUT_EN adds a bus timeout that
//               forces completion with ArbErrData and a bus_err_o pulse.
// Revision    : 1.0  initial release
// Ports       : clk_i/rst_n                clock, async active-low reset
//               if_req_i/if_addr_i         IF read request (level)
//               if_rdata_o/if_ack_o        IF read data and completion pulse
//               mem_req_i/mem_we_i/...     MEM request, direction, addr, data
//               mem_rdata_o/mem_ack_o      MEM load data and completion pulse
//               bus_*_o / bus_*_i          memory-side req/ack bus
//               stall_if_o/stall_mem_o     combinational pipeline stalls
//               owner_o                    0 none, 1 IF, 2 MEM
//               bus_err_o                  timeout pulse (0 without macro)
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic [1:0]        owner_o,
    output logic              bus_err_o
);

    arb_state_e        state_q,     state_d;
    arb_owner_e        owner_q,     owner_d;
    logic              bus_req_q,   bus_req_d;
    logic              bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              mem_ack_q,   mem_ack_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              bus_err_q,   bus_err_d;

    logic w_timeout;
    logic w_grant_mem;
    logic w_grant_if;

`ifdef MEM_ARBITER_TIMEOUT_EN
    mem_arbiter_watchdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .in_bus_i  (state_q == ArbBus),
        .expired_o (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        w_grant_mem = 1'b0;
        w_grant_if  = 1'b0;

        unique case (state_q)
            ArbIdle: begin
                w_grant_mem = mem_req_i;
                w_grant_if  = if_req_i && !mem_req_i;
            end
            ArbBus: begin
                // A real ack beats a same-cycle timeout.
                if (bus_ack_i || w_timeout) begin
                    state_d   = ArbResp;
                    bus_req_d = 1'b0;
                    bus_err_d = !bus_ack_i;
                    if (owner_q == OwnMem) begin
                        mem_ack_d = 1'b1;
                        if (!bus_ack_i) begin
                            mem_rdata_d = DATA_W'(ArbErrData);
                        end else if (!bus_we_q) begin
                            mem_rdata_d = bus_rdata_i;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_ack_i ? bus_rdata_i : DATA_W'(ArbErrData);
                    end
                end
            end
            ArbResp: begin
                // The requester just served still shows its old req; only the
                // other side may be granted from here.
                w_grant_mem = (owner_q == OwnIf)  && mem_req_i;
                w_grant_if  = (owner_q == OwnMem) && if_req_i;
                state_d     = ArbIdle;
                owner_d     = OwnNone;
            end
            default: begin
                state_d = ArbIdle;
                owner_d = OwnNone;
            end
        endcase

        if (w_grant_mem) begin
            state_d     = ArbBus;
            owner_d     = OwnMem;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_we_i;
            bus_addr_d  = mem_addr_i;
            bus_wdata_d = mem_wdata_i;
        end else if (w_grant_if) begin
            state_d    = ArbBus;
            owner_d    = OwnIf;
            bus_req_d  = 1'b1;
            bus_we_d   = 1'b0;
            bus_addr_d = if_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ArbIdle;
            owner_q     <= OwnNone;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_ack_o   = mem_ack_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign owner_o     = owner_q;
    assign bus_err_o   = bus_err_q;

    // Stalls use the registered ack so they drop in the ack cycle itself.
    assign stall_if_o  = if_req_i  && !if_ack_q;
    assign stall_mem_o = mem_req_i && !mem_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed requester
//               sequences push expected responses into a scoreboard queue; a
//               monitor pops and compares on every if_ack/mem_ack. A simple
//               memory responder with configurable wait states serves the bus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_if;
    logic        stall_mem;
    logic [1:0]  owner;
    logic        bus_err;

    logic        resp_ack;
    logic        stray_ack;
    int          mem_wait;
    logic [31:0] mem_model [logic [31:0]];

    typedef struct {
        bit          is_mem;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign bus_ack = resp_ack | stray_ack;

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT     (16)
    ) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_ack_o    (if_ack),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .mem_ack_o   (mem_ack),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_rdata_i (bus_rdata),
        .bus_ack_i   (bus_ack),
        .stall_if_o  (stall_if),
        .stall_mem_o (stall_mem),
        .owner_o     (owner),
        .bus_err_o   (bus_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_mem, input logic [31:0] rdata);
        exp_t e;
        e.is_mem = is_mem;
        e.rdata  = rdata;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input bit is_mem, input int budget, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(is_mem ? mem_ack : if_ack) && lat < budget);
        if (!(is_mem ? mem_ack : if_ack)) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_wait: no ack after %0d cycles, required an ack", lat);
        end
    endtask

    // Memory responder: acks after mem_wait extra cycles of bus_req.
    initial begin
        int wcnt;
        wcnt      = 0;
        resp_ack  = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus_req) begin
                if (wcnt >= mem_wait) begin
                    resp_ack = 1'b1;
                    if (bus_we) begin
                        mem_model[bus_addr] = bus_wdata;
                    end else begin
                        bus_rdata = mem_model.exists(bus_addr) ? mem_model[bus_addr] : 32'h0;
                    end
                end else begin
                    resp_ack = 1'b0;
                end
                wcnt++;
            end else begin
                resp_ack = 1'b0;
                wcnt     = 0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            tick();
            if (rst_n === 1'b1 && (if_ack || mem_ack)) begin
                if (if_ack && mem_ack) begin
                    chk("sb_dual_ack", 32'd1, 32'd0);
                end
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected_ack: got if_ack=%0b mem_ack=%0b, required no ack", if_ack, mem_ack);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ack_side", {31'd0, mem_ack}, {31'd0, e.is_mem});
                    chk("sb_rdata", mem_ack ? mem_rdata : if_rdata, e.rdata);
`ifndef MEM_ARBITER_TIMEOUT_EN
                    chk("sb_bus_err", {31'd0, bus_err}, 32'd0);
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stray_ack = 1'b0;
        mem_wait  = 0;
        mem_model[32'h100] = 32'h2002000A;
        mem_model[32'h104] = 32'hCAFEF00D;
        mem_model[32'h080] = 32'h12345678;
        mem_model[32'h084] = 32'h0BADF00D;

        // Reset state.
        repeat (2) tick();
        chk("rst_bus_req",   {31'd0, bus_req}, 32'd0);
        chk("rst_owner",     {30'd0, owner},   32'd0);
        chk("rst_if_ack",    {31'd0, if_ack},  32'd0);
        chk("rst_mem_ack",   {31'd0, mem_ack}, 32'd0);
        chk("rst_if_rdata",  if_rdata,         32'd0);
        chk("rst_mem_rdata", mem_rdata,        32'd0);
        chk("rst_bus_addr",  bus_addr,         32'd0);
        chk("rst_bus_err",   {31'd0, bus_err}, 32'd0);
        if_req = 1'b1;
        #1;
        chk("rst_stall_if_eq", {31'd0, stall_if}, 32'd1);
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single IF read, memory acks in first bus cycle.
        if_req  = 1'b1;
        if_addr = 32'h100;
        push(1'b0, 32'h2002000A);
        #1;
        chk("t1_stall_c0", {31'd0, stall_if}, 32'd1);
        tick();
        chk("t1_bus_req_c1", {31'd0, bus_req}, 32'd1);
        chk("t1_owner_c1",   {30'd0, owner},   32'd1);
        chk("t1_bus_addr",   bus_addr,         32'h100);
        chk("t1_bus_we",     {31'd0, bus_we},  32'd0);
        chk("t1_stall_c1",   {31'd0, stall_if}, 32'd1);
        tick();
        chk("t1_if_ack_c2",  {31'd0, if_ack},  32'd1);
        chk("t1_bus_req_c2", {31'd0, bus_req}, 32'd0);
        chk("t1_stall_c2",   {31'd0, stall_if}, 32'd0);
        tick();
        if_req = 1'b0;
        chk("t1_owner_idle", {30'd0, owner},   32'd0);
        chk("t1_if_ack_c3",  {31'd0, if_ack},  32'd0);

        // Stray bus_ack while idle must be ignored.
        stray_ack = 1'b1;
        repeat (2) tick();
        stray_ack = 1'b0;
        chk("stray_owner",   {30'd0, owner},   32'd0);
        chk("stray_bus_req", {31'd0, bus_req}, 32'd0);

        // MEM read with three memory wait cycles.
        mem_wait = 3;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h80;
        push(1'b1, 32'h12345678);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t3_bus_req",   {31'd0, bus_req},   32'd1);
            chk("t3_bus_addr",  bus_addr,           32'h80);
            chk("t3_owner",     {30'd0, owner},     32'd2);
            chk("t3_stall_mem", {31'd0, stall_mem}, 32'd1);
            chk("t3_no_ack",    {31'd0, mem_ack},   32'd0);
        end
        tick();
        chk("t3_mem_ack_c5", {31'd0, mem_ack},   32'd1);
        chk("t3_stall_c5",   {31'd0, stall_mem}, 32'd0);
        tick();
        mem_req  = 1'b0;
        mem_wait = 0;

        // Simultaneous IF read and MEM write: MEM first, IF granted from RESP.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h40;
        mem_wdata = 32'h55;
        if_req    = 1'b1;
        if_addr   = 32'h104;
        push(1'b1, 32'h12345678);
        push(1'b0, 32'hCAFEF00D);
        tick();
        chk("t2_owner_mem",  {30'd0, owner},    32'd2);
        chk("t2_bus_we",     {31'd0, bus_we},   32'd1);
        chk("t2_bus_addr",   bus_addr,          32'h40);
        chk("t2_bus_wdata",  bus_wdata,         32'h55);
        tick();
        chk("t2_mem_ack",    {31'd0, mem_ack},  32'd1);
        chk("t2_if_stalled", {31'd0, stall_if}, 32'd1);
        tick();
        mem_req = 1'b0;
        mem_we  = 1'b0;
        chk("t2_owner_if",   {30'd0, owner},    32'd1);
        chk("t2_bus_we_if",  {31'd0, bus_we},   32'd0);
        chk("t2_bus_addr_if", bus_addr,         32'h104);
        chk("t2_bus_req_if", {31'd0, bus_req},  32'd1);
        tick();
        chk("t2_if_ack",     {31'd0, if_ack},   32'd1);
        chk("t2_mem_written", mem_model.exists(32'h40) ? mem_model[32'h40] : 32'h0, 32'h55);
        tick();
        if_req = 1'b0;

        // mem_req rises while IF owns the bus: no preemption.
        mem_wait = 2;
        if_req   = 1'b1;
        if_addr  = 32'h100;
        push(1'b0, 32'h2002000A);
        tick();
        chk("t4_owner_if_c1", {30'd0, owner}, 32'd1);
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h84;
        push(1'b1, 32'h0BADF00D);
        tick();
        chk("t4_owner_if_c2", {30'd0, owner}, 32'd1);
        chk("t4_addr_c2",     bus_addr,       32'h100);
        tick();
        chk("t4_owner_if_c3", {30'd0, owner}, 32'd1);
        tick();
        chk("t4_if_ack",      {31'd0, if_ack},  32'd1);
        chk("t4_no_mem_ack",  {31'd0, mem_ack}, 32'd0);
        tick();
        if_req = 1'b0;
        chk("t4_owner_mem",   {30'd0, owner}, 32'd2);
        chk("t4_addr_mem",    bus_addr,       32'h84);
        wait_ack(1'b1, 10, lat);
        chk("t4_mem_lat",     lat, 32'd3);
        tick();
        mem_req  = 1'b0;
        mem_wait = 0;

        // Asynchronous reset while in BUS.
        mem_wait = 1000;
        if_req   = 1'b1;
        if_addr  = 32'h104;
        tick();
        chk("t5_bus_req_pre", {31'd0, bus_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_bus_req",   {31'd0, bus_req}, 32'd0);
        chk("t5_owner",     {30'd0, owner},   32'd0);
        chk("t5_if_ack",    {31'd0, if_ack},  32'd0);
        chk("t5_mem_ack",   {31'd0, mem_ack}, 32'd0);
        chk("t5_if_rdata",  if_rdata,         32'd0);
        chk("t5_mem_rdata", mem_rdata,        32'd0);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        mem_wait = 0;
        tick();
        chk("t5_owner_idle", {30'd0, owner}, 32'd0);
        if_req  = 1'b1;
        if_addr = 32'h104;
        push(1'b0, 32'hCAFEF00D);
        wait_ack(1'b0, 10, lat);
        chk("t5_if_lat", lat, 32'd2);
        tick();
        if_req = 1'b0;

`ifdef MEM_ARBITER_TIMEOUT_EN
        // Memory never answers: forced completion after 16 BUS cycles.
        mem_wait = 1_000_000;
        if_req   = 1'b1;
        if_addr  = 32'h100;
        push(1'b0, 32'hDEADBEEF);
        wait_ack(1'b0, 40, lat);
        chk("t6_to_lat",     lat,              32'd17);
        chk("t6_bus_err",    {31'd0, bus_err}, 32'd1);
        tick();
        if_req = 1'b0;
        chk("t6_bus_err_end", {31'd0, bus_err}, 32'd0);
        mem_wait = 0;
`endif

        repeat (3) tick();
        chk("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
